uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; a power of two, at least 2.
REQ-002 Parameter BASE_HI, default 12'h300: required value of wbs_adr_i[31:20] for decode.
REQ-003 wb_clk_i  in  1: the single clock; every flop samples on its rising edge.
REQ-004 wb_rst_i  in  1: reset, synchronous and active-low.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each: Wishbone strobe, cycle and write-enable.
REQ-006 wbs_sel_i  in  4: byte selects.
REQ-007 wbs_adr_i  in  32: byte address.
REQ-008 wbs_dat_i  in  32: write data.
REQ-009 wbs_ack_o  out  1: single-cycle acknowledge.
REQ-010 wbs_dat_o  out  32: read data.
REQ-011 tx_valid  out  1: a byte is offered to the downstream UART serializer.
REQ-012 tx_data  out  8: the offered byte.
REQ-013 tx_ready  in  1: the serializer accepts tx_data.
REQ-014 irq_o  out  1: level interrupt.

Function
REQ-015 Request decode: req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20]==BASE_HI); register offset is wbs_adr_i[3:2].
REQ-016 Acknowledge timing:
- wbs_ack_o asserts exactly one cycle after any cycle where req=1 and wbs_ack_o=0.
- wbs_ack_o stays high for one cycle only.
- The register side effect occurs on the same edge that raises ack.
REQ-017 Read data: wbs_dat_o carries read data only while wbs_ack_o=1; it is 0 otherwise.
REQ-018 Offset 0, TXDATA:
- A write with wbs_sel_i[0]=1 pushes wbs_dat_i[7:0].
- A write with wbs_sel_i[0]=0 pushes nothing.
- A read returns 0.
REQ-019 Offset 1, STATUS (read-only):
- bit0 empty, bit1 full, bit2 overflow (sticky).
- bits[8+W:8] count, where W = clog2(DEPTH).
- All other bits read 0.
REQ-020 Offset 2, CTRL:
- bit0 en: drain enable, read/write.
- bit1 ie: interrupt enable, read/write.
- bit2 flush: write-1 pulse, reads 0.
- bit3 clr_ovf: write-1 pulse, reads 0.
REQ-021 Offset 3 reads 0; writes to it are ignored.
REQ-022 Push acceptance: a push is accepted only if full=0 in that cycle; a same-cycle pop does not free a slot for it.
REQ-023 Push into a full FIFO: the data is dropped and overflow is set.
REQ-024 Drain side: tx_valid = en & !empty; tx_data = head entry (show-ahead, combinational from storage).
REQ-025 Pop happens when tx_valid & tx_ready.
REQ-026 tx_data stays stable while tx_valid=1 and tx_ready=0.
REQ-027 Simultaneous accepted push and pop: count is unchanged and both pointers advance.
REQ-028 Pointers: read and write pointers are W bits and wrap modulo DEPTH; count is W+1 bits, range 0..DEPTH.
REQ-029 Flush:
- Pointers and count go to 0 on the next edge.
- Flush overrides any same-cycle push or pop; the dropped push does not set overflow.
- en, ie and overflow are unaffected.
REQ-030 Overflow clear: clr_ovf clears overflow; if it coincides with an overflowing push, overflow ends set.
REQ-031 Interrupt: irq_o = ie & en & empty, registered (one cycle after the condition).
REQ-032 Clearing en while tx_valid=1 deasserts tx_valid in the same cycle the new en value is visible; the head entry is retained.

Reset
REQ-033 When wb_rst_i=0 at a rising edge, the following clear: pointers, count, en, ie, overflow, wbs_ack_o and irq_o.
REQ-034 Output values while in reset: tx_valid=0, wbs_dat_o=0.
REQ-035 Reset applied mid-transaction drops any pending ack; storage contents need not be cleared.

Structure
REQ-036 A shared package holds:
- the register offset constants (TXDATA=0, STATUS=1, CTRL=2);
- the STATUS and CTRL bit-position constants;
- the BASE_HI default.
REQ-037 One sub-module, sync_fifo:
- parameterised storage, pointers and count;
- push/pop/flush inputs; full/empty/count/head outputs.
REQ-038 The Wishbone register decode and ack logic live in uart_tx_fifo itself.

Verification
REQ-039 Reset then read STATUS (0x3000_0004) -> ack one cycle later; data 0x0000_0001.
REQ-040 Set en=0, write 0x41, 0x42, 0x43 to TXDATA, then read STATUS -> count=3; set en=1 with tx_ready=1 -> tx_data 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0 and STATUS=0x0000_0001.
REQ-041 With en=0, write 9 bytes 0x00..0x08 -> STATUS=0x0000_0806 (count 8, full, overflow); drain -> bytes 0x00..0x07 only; write CTRL=0x9 -> overflow cleared.
REQ-042 Hold tx_ready=0 with 2 entries and en=1 -> tx_valid=1 and tx_data held for 10 cycles; pulse tx_ready for one cycle -> exactly one pop, count=1.
REQ-043 Push and pop in the same cycle at count=DEPTH-1 -> count stays 7, no overflow; then push with tx_ready=1 while full -> data dropped, overflow=1.
REQ-044 Flush (CTRL=0x5) at count=5 with a simultaneous pop -> count=0 next cycle; en still 1; overflow unchanged; no data from before the flush is emitted.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared register map and bit positions for the UART transmit FIFO block.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_e;

  localparam int STATUS_EMPTY   = 0;
  localparam int STATUS_FULL    = 1;
  localparam int STATUS_OVF     = 2;
  localparam int STATUS_CNT_LSB = 8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_FLUSH   = 2;
  localparam int CTRL_CLR_OVF = 3;

  localparam logic [11:0] BASE_HI_DEFAULT = 12'h300;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Wishbone slave bus bundle for the UART transmit FIFO.
interface uart_tx_fifo_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: head is the oldest entry, combinational from storage.
// A push is refused when full even if a pop happens in the same cycle; flush wins over both.
module sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [W:0]       count,
  output logic [WIDTH-1:0] head
);

  localparam logic [W:0] FULL_CNT = (W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [W-1:0]     wr_ptr;
  logic [W-1:0]     rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are left alone by reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Wishbone-mapped transmit FIFO feeding a UART serializer, with status, control and a level IRQ.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [11:0] BASE_HI = BASE_HI_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  uart_tx_fifo_if.slave    wb,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             irq_o
);

  localparam int W = $clog2(DEPTH);

  logic        req, access;
  logic        ack_q;
  logic [31:0] rdat_q, rd_val;
  reg_off_e    off;
  logic        en_q, ie_q, ovf_q, irq_q;
  logic        wr_ctrl, push, pop, flush, clr_ovf;
  logic        fifo_full, fifo_empty;
  logic [W:0]  fifo_count;
  logic [7:0]  fifo_head;
  logic        unused_bits;

  // A request already being acknowledged is not serviced again until ack drops.
  assign req     = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:20] == BASE_HI);
  assign access  = req & ~ack_q;
  assign off     = reg_off_e'(wb.wbs_adr_i[3:2]);
  assign push    = access & wb.wbs_we_i & (off == REG_TXDATA) & wb.wbs_sel_i[0];
  assign wr_ctrl = access & wb.wbs_we_i & (off == REG_CTRL);
  assign flush   = wr_ctrl & wb.wbs_dat_i[CTRL_FLUSH];
  assign clr_ovf = wr_ctrl & wb.wbs_dat_i[CTRL_CLR_OVF];

  assign tx_valid = wb_rst_i & en_q & ~fifo_empty;
  assign tx_data  = fifo_head;
  assign pop      = tx_valid & tx_ready;
  assign irq_o    = irq_q;

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = (wb_rst_i & ack_q) ? rdat_q : '0;

  assign unused_bits = ^{wb.wbs_sel_i[3:1], wb.wbs_adr_i[19:4], wb.wbs_adr_i[1:0],
                         wb.wbs_dat_i[31:8]};

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_i),
    .push      (push),
    .push_data (wb.wbs_dat_i[7:0]),
    .pop       (pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Read mux over the pre-edge register state.
  always_comb begin
    rd_val = '0;
    case (off)
      REG_STATUS: begin
        rd_val[STATUS_EMPTY]               = fifo_empty;
        rd_val[STATUS_FULL]                = fifo_full;
        rd_val[STATUS_OVF]                 = ovf_q;
        rd_val[STATUS_CNT_LSB +: W+1]      = fifo_count;
      end
      REG_CTRL: begin
        rd_val[CTRL_EN] = en_q;
        rd_val[CTRL_IE] = ie_q;
      end
      default: rd_val = '0;
    endcase
  end

  // Single-cycle ack with read data captured on the same edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q  <= access;
      rdat_q <= (access & ~wb.wbs_we_i) ? rd_val : '0;
    end
  end

  // Control bits, sticky overflow (a same-edge overflow beats clear) and registered IRQ.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q <= wb.wbs_dat_i[CTRL_EN];
        ie_q <= wb.wbs_dat_i[CTRL_IE];
      end
      if (clr_ovf) ovf_q <= 1'b0;
      if (push && fifo_full && !flush) ovf_q <= 1'b1;
      irq_q <= ie_q & en_q & fifo_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: register vector table, directed corner sequences, random run vs a queue model.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       irq;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(.DEPTH(DEPTH), .BASE_HI(12'h300)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb       (bus),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] pop_log[$];
  int         pop_cyc[$];

  // Record every byte the serializer accepts, with the cycle it happened in.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_valid && tx_ready) begin
      pop_log.push_back(tx_data);
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [1:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] logged(int i);
    if (i < pop_log.size()) return {24'b0, pop_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic do_reset();
    bus_idle();
    tx_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One bus transfer; optionally raise tx_ready for exactly the access edge.
  task automatic wb_xfer(input logic we, input logic [1:0] off, input logic [31:0] dat,
                         input logic [3:0] sel, input bit pulse_rdy, output logic [31:0] rdat);
    int waited = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = {12'h300, 16'h0, off, 2'b00};
    bus.wbs_dat_i = dat;
    if (pulse_rdy) tx_ready = 1'b1;
    rdat = 32'hDEAD_BEEF;
    tick();
    if (pulse_rdy) tx_ready = 1'b0;
    while (bus.wbs_ack_o !== 1'b1 && waited < 4) begin
      tick();
      waited++;
    end
    chk("ack_latency", waited, 0);
    if (bus.wbs_ack_o === 1'b1) rdat = bus.wbs_dat_o;
    bus_idle();
    tick();
    chk("ack_single", {31'b0, bus.wbs_ack_o}, 32'h0);
  endtask

  task automatic wb_write(input logic [1:0] off, input logic [31:0] dat);
    logic [31:0] r;
    wb_xfer(1'b1, off, dat, 4'hF, 1'b0, r);
  endtask

  task automatic read_chk(input string name, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, off, 32'h0, 4'hF, 1'b0, r);
    chk(name, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  exp43[9];
    logic [7:0]  mq[$];
    bit          m_en, m_ie, m_ovf, m_irq, m_ack, m_ack_rd;
    logic [31:0] m_rdat, rv, rnd, dat;
    bit          r_ready, c_on, s_on, hit, we, req, access, pop, push, wctrl, flush, clr;
    bit          full_pre, empty_pre;
    logic [1:0]  off;
    logic [3:0]  sel;
    int          k, pre_size;

    bus_idle();
    do_reset();

    // Reset state and register-map vectors.
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_ack", bus.wbs_ack_o, 0);
    chk("rst_irq", irq, 0);
    chk("rst_dat", bus.wbs_dat_o, 0);

    vt.push_back('{1'b0, 2'd1, 32'h0,        4'hF, 32'h0000_0001});
    vt.push_back('{1'b0, 2'd2, 32'h0,        4'hF, 32'h0});
    vt.push_back('{1'b0, 2'd0, 32'h0,        4'hF, 32'h0});
    vt.push_back('{1'b1, 2'd2, 32'h3,        4'hF, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h0,        4'hF, 32'h3});
    vt.push_back('{1'b1, 2'd2, 32'hF,        4'hF, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h0,        4'hF, 32'h3});
    vt.push_back('{1'b1, 2'd2, 32'h0,        4'hF, 32'h0});
    vt.push_back('{1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vt.push_back('{1'b0, 2'd3, 32'h0,        4'hF, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h0,        4'hF, 32'h0});
    vt.push_back('{1'b1, 2'd0, 32'h55,       4'hE, 32'h0});
    vt.push_back('{1'b0, 2'd1, 32'h0,        4'hF, 32'h0000_0001});
    vt.push_back('{1'b1, 2'd0, 32'h66,       4'h1, 32'h0});
    vt.push_back('{1'b0, 2'd1, 32'h0,        4'hF, 32'h0000_0100});
    vt.push_back('{1'b0, 2'd0, 32'h0,        4'hF, 32'h0});
    vt.push_back('{1'b1, 2'd1, 32'hFFFF,     4'hF, 32'h0});
    vt.push_back('{1'b0, 2'd1, 32'h0,        4'hF, 32'h0000_0100});
    vt.push_back('{1'b1, 2'd2, 32'h4,        4'hF, 32'h0});
    vt.push_back('{1'b0, 2'd1, 32'h0,        4'hF, 32'h0000_0001});
    for (int i = 0; i < vt.size(); i++) begin
      wb_xfer(vt[i].we, vt[i].off, vt[i].dat, vt[i].sel, 1'b0, r);
      if (!vt[i].we) chk($sformatf("vec%0d", i), r, vt[i].exp);
    end

    // Address outside the window gets no ack.
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = 32'h3010_0004;
    k = 0;
    repeat (3) begin
      tick();
      if (bus.wbs_ack_o === 1'b1) k++;
    end
    chk("no_ack_off_window", k, 0);
    bus_idle();
    tick();

    // IRQ follows ie & en & empty one cycle later.
    wb_write(2'd2, 32'h3);
    chk("irq_set", irq, 1);
    wb_write(2'd0, 32'h99);
    chk("irq_clear", irq, 0);
    wb_write(2'd2, 32'h4);

    // Three bytes drain back to back once enabled.
    do_reset();
    wb_write(2'd0, 32'h41);
    wb_write(2'd0, 32'h42);
    wb_write(2'd0, 32'h43);
    read_chk("r40_status3", 2'd1, 32'h0000_0300);
    pop_log.delete();
    pop_cyc.delete();
    tx_ready = 1'b1;
    wb_write(2'd2, 32'h1);
    repeat (5) tick();
    chk("r40_npop", pop_log.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("r40_byte%0d", i), logged(i), 32'h41 + i);
    if (pop_cyc.size() >= 3) chk("r40_consecutive", pop_cyc[2] - pop_cyc[0], 2);
    chk("r40_valid_low", tx_valid, 0);
    tx_ready = 1'b0;
    read_chk("r40_status_end", 2'd1, 32'h0000_0001);

    // Overfill, drain only the first DEPTH bytes, clear overflow.
    wb_write(2'd2, 32'h0);
    for (int i = 0; i < 9; i++) wb_write(2'd0, i);
    read_chk("r41_status_full", 2'd1, 32'h0000_0806);
    pop_log.delete();
    tx_ready = 1'b1;
    wb_write(2'd2, 32'h1);
    repeat (12) tick();
    tx_ready = 1'b0;
    chk("r41_npop", pop_log.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("r41_byte%0d", i), logged(i), i);
    wb_write(2'd2, 32'h9);
    read_chk("r41_ovf_cleared", 2'd1, 32'h0000_0001);

    // Backpressure holds the head; a one-cycle ready pops exactly one.
    wb_write(2'd0, 32'hA0);
    wb_write(2'd0, 32'hA1);
    pop_log.delete();
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'hA0) k++;
      tick();
    end
    chk("r42_hold_cycles_bad", k, 0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    tick();
    chk("r42_npop", pop_log.size(), 1);
    chk("r42_popped", logged(0), 32'hA0);
    chk("r42_next_head", tx_data, 8'hA1);
    read_chk("r42_status", 2'd1, 32'h0000_0100);
    wb_write(2'd2, 32'h5);
    read_chk("r42_flushed", 2'd1, 32'h0000_0001);

    // Push+pop at DEPTH-1, then a push into full with a pop: refused, overflow.
    for (int i = 0; i < 7; i++) wb_write(2'd0, 32'h10 + i);
    pop_log.delete();
    wb_xfer(1'b1, 2'd0, 32'h17, 4'hF, 1'b1, r);
    read_chk("r43_count7", 2'd1, 32'h0000_0700);
    wb_write(2'd0, 32'h18);
    read_chk("r43_full", 2'd1, 32'h0000_0802);
    wb_xfer(1'b1, 2'd0, 32'hEE, 4'hF, 1'b1, r);
    read_chk("r43_dropped_ovf", 2'd1, 32'h0000_0704);
    tx_ready = 1'b1;
    repeat (12) tick();
    tx_ready = 1'b0;
    exp43 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    chk("r43_npop", pop_log.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("r43_byte%0d", i), logged(i), {24'b0, exp43[i]});
    wb_write(2'd2, 32'h9);

    // Flush with a same-cycle pop at count 5; en and overflow survive.
    wb_write(2'd2, 32'h0);
    for (int i = 0; i < 9; i++) wb_write(2'd0, 32'h20 + i);
    wb_write(2'd2, 32'h4);
    read_chk("r44_flush_keeps_ovf", 2'd1, 32'h0000_0005);
    wb_write(2'd2, 32'h1);
    for (int i = 0; i < 5; i++) wb_write(2'd0, 32'h30 + i);
    read_chk("r44_count5", 2'd1, 32'h0000_0504);
    wb_xfer(1'b1, 2'd2, 32'h5, 4'hF, 1'b1, r);
    pop_log.delete();
    tx_ready = 1'b1;
    repeat (5) tick();
    tx_ready = 1'b0;
    chk("r44_no_stale_bytes", pop_log.size(), 0);
    chk("r44_valid_low", tx_valid, 0);
    read_chk("r44_status", 2'd1, 32'h0000_0005);
    read_chk("r44_en_kept", 2'd2, 32'h0000_0001);

    // Reset during a pending request.
    wb_write(2'd0, 32'h77);
    chk("midrst_pre_valid", tx_valid, 1);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = 32'h3000_0004;
    rst_n = 1'b0;
    tick();
    chk("midrst_ack", bus.wbs_ack_o, 0);
    chk("midrst_valid", tx_valid, 0);
    chk("midrst_dat", bus.wbs_dat_o, 0);
    chk("midrst_irq", irq, 0);
    bus_idle();
    tick();
    rst_n = 1'b1;
    tick();
    read_chk("midrst_ctrl", 2'd2, 32'h0);
    read_chk("midrst_status", 2'd1, 32'h0000_0001);

    // Random traffic against a queue-based model.
    do_reset();
    mq.delete();
    m_en = 0; m_ie = 0; m_ovf = 0; m_irq = 0; m_ack = 0; m_ack_rd = 0; m_rdat = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", tx_valid, (m_en && mq.size() > 0));
      if (m_en && mq.size() > 0) chk("rnd_data", tx_data, mq[0]);
      chk("rnd_ack", bus.wbs_ack_o, m_ack);
      chk("rnd_irq", irq, m_irq);
      if (m_ack_rd) chk("rnd_rdat", bus.wbs_dat_o, m_rdat);
      else if (!m_ack) chk("rnd_rdat_idle", bus.wbs_dat_o, 0);

      r_ready = ($urandom_range(0, 3) != 0);
      c_on    = ($urandom_range(0, 1) != 0);
      s_on    = c_on && ($urandom_range(0, 7) != 0);
      hit     = ($urandom_range(0, 7) != 0);
      k       = $urandom_range(0, 9);
      off     = (k < 5) ? 2'd0 : (k < 7) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
      we      = ($urandom_range(0, 3) != 0);
      rnd     = $urandom();
      sel     = rnd[3:0];
      dat     = $urandom();
      if (off == 2'd2) begin
        dat[0] = ($urandom_range(0, 3) != 0);
        dat[2] = ($urandom_range(0, 15) == 0);
        dat[3] = ($urandom_range(0, 3) == 0);
      end
      tx_ready      = r_ready;
      bus.wbs_cyc_i = c_on;
      bus.wbs_stb_i = s_on;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_adr_i = {hit ? 12'h300 : 12'h301, rnd[27:12], off, 2'b00};
      bus.wbs_dat_i = dat;

      pre_size  = mq.size();
      full_pre  = (pre_size == DEPTH);
      empty_pre = (pre_size == 0);
      req       = c_on && s_on && hit;
      access    = req && !m_ack;
      pop       = m_en && !empty_pre && r_ready;
      rv = 32'h0;
      if (off == 2'd1) rv = (pre_size << 8) | (m_ovf << 2) | (full_pre << 1) | empty_pre;
      else if (off == 2'd2) rv = {30'b0, m_ie, m_en};
      push  = access && we && (off == 2'd0) && sel[0];
      wctrl = access && we && (off == 2'd2);
      flush = wctrl && dat[2];
      clr   = wctrl && dat[3];
      m_irq = m_ie && m_en && empty_pre;
      if (flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push && !full_pre) mq.push_back(dat[7:0]);
      end
      if (clr) m_ovf = 0;
      if (push && full_pre && !flush) m_ovf = 1;
      if (wctrl) begin
        m_en = dat[0];
        m_ie = dat[1];
      end
      m_ack    = access;
      m_ack_rd = access && !we;
      m_rdat   = rv;
      tick();
    end
    bus_idle();
    tx_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
